// File: rtl/mcu_spi_select_if.sv
// SPI signal bundle between the MCU links and the core's single mcu_* port.
// master: the side driving the MCU pins and the core return path (board / bench).
// slave:  the channel selector itself.
interface mcu_spi_select_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] mcu_sclk_in;
    logic [CHANNELS-1:0] mcu_csn_in;
    logic [CHANNELS-1:0] mcu_mosi_in;
    logic [CHANNELS-1:0] mcu_miso_out;
    logic [CHANNELS-1:0] mcu_intn_out;
    logic                core_sclk;
    logic                core_csn;
    logic                core_mosi;
    logic                core_miso;
    logic                core_intn;

    modport master (
        output mcu_sclk_in, mcu_csn_in, mcu_mosi_in, core_miso, core_intn,
        input  mcu_miso_out, mcu_intn_out, core_sclk, core_csn, core_mosi
    );

    modport slave (
        input  mcu_sclk_in, mcu_csn_in, mcu_mosi_in, core_miso, core_intn,
        output mcu_miso_out, mcu_intn_out, core_sclk, core_csn, core_mosi
    );
endinterface

// File: rtl/mcu_spi_select.sv
// Automatic, glitch-free selection of one of several MCU SPI links onto the
// core's single MCU SPI port, driven by chip-select activity.
// A link is locked on its synchronised csn falling, kept while it is active,
// and released only after its csn has stayed high for HOLDOFF cycles.
// Optional macro MCU_SPI_SEL_STICKY_EN: the first link locked after reset is
// kept until the next reset (holdoff expiry never returns to IDLE).
module mcu_spi_select #(
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 64,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNT_W      = $clog2(HOLDOFF)
) (
    input  logic              clk32,
    input  logic              reset,
    mcu_spi_select_if.slave   bus,
    output logic [SEL_W-1:0]  sel,
    output logic              locked,
    output logic [7:0]        collisions
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

    state_t              state, state_nx;
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] cs_s;
    logic [CHANNELS-1:0] cs_d;
    logic [SEL_W-1:0]    sel_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [7:0]          coll_nx;
    logic [3:0]          falls;
    logic                routed;

    // Add k rejected accesses to the count, clamping at 255.
    function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [3:0] k);
        logic [8:0] sum;
        sum = {1'b0, base} + {5'd0, k};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign cs_s = sync_q[SYNC_STAGES-1];

    // csn synchronisers plus the delayed copy for falling-edge detection; idle level is high.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
            cs_d <= '1;
        end else begin
            sync_q[0] <= bus.mcu_csn_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            cs_d <= cs_s;
        end
    end

    // State register with the selection, holdoff counter and collision counter.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            cnt        <= '0;
            collisions <= '0;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            cnt        <= cnt_nx;
            collisions <= coll_nx;
        end
    end

    // Next-state logic: lock the lowest active link, release after the holdoff.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (cs_s != '1) begin
                    for (int i = CHANNELS - 1; i >= 0; i--) begin
                        if (!cs_s[i]) sel_nx = SEL_W'(i);
                    end
                    state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (cs_s[sel]) begin
                    state_nx = RELEASE;
                    cnt_nx   = '0;
                end
            end
            RELEASE: begin
                if (!cs_s[sel]) begin
                    state_nx = LOCKED;
                end else if (cnt == HOLD_LAST) begin
`ifdef MCU_SPI_SEL_STICKY_EN
                    state_nx = LOCKED;
`else
                    state_nx = IDLE;
`endif
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Collision accounting: synced csn falls on any non-selected link while owned.
    always_comb begin
        falls = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if ((SEL_W'(j) != sel) && cs_d[j] && !cs_s[j]) falls = falls + 4'd1;
        end
        coll_nx = (state != IDLE) ? sat_add(collisions, falls) : collisions;
    end

    // Output routing: raw pins of the selected link while owned, safe idle levels otherwise.
    always_comb begin
        routed           = (state != IDLE);
        locked           = routed;
        bus.core_csn     = 1'b1;
        bus.core_sclk    = 1'b0;
        bus.core_mosi    = 1'b1;
        bus.mcu_miso_out = '1;
        bus.mcu_intn_out = {CHANNELS{bus.core_intn}};
        if (routed) begin
            bus.core_csn          = bus.mcu_csn_in[sel];
            bus.core_sclk         = bus.mcu_sclk_in[sel];
            bus.core_mosi         = bus.mcu_mosi_in[sel];
            bus.mcu_miso_out[sel] = bus.core_miso;
            bus.mcu_intn_out      = '1;
            bus.mcu_intn_out[sel] = bus.core_intn;
        end
    end

endmodule

// File: tb/tb_mcu_spi_select.sv
// Bench for mcu_spi_select (CHANNELS=2, SYNC_STAGES=2, HOLDOFF=64).
// A link-ownership reference model (owner, consecutive-high run, saturating
// collision tally over a delayed csn history) is checked every cycle, alongside
// directed checks for reset, lock latency, tie, holdoff, saturation and reset
// mid-transfer. Build with MCU_SPI_SEL_STICKY_EN to exercise the sticky variant.
module tb_mcu_spi_select;
    localparam int CH = 2;
    localparam int SS = 2;
    localparam int HO = 64;

    logic       clk32 = 1'b0;
    logic       reset = 1'b1;
    logic [0:0] sel;
    logic       locked;
    logic [7:0] collisions;

    always #5 clk32 = ~clk32;

    mcu_spi_select_if #(.CHANNELS(CH)) bus ();

    mcu_spi_select #(.CHANNELS(CH), .SYNC_STAGES(SS), .HOLDOFF(HO)) dut (
        .clk32      (clk32),
        .reset      (reset),
        .bus        (bus.slave),
        .sel        (sel),
        .locked     (locked),
        .collisions (collisions)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          owner;
    int          m_sel;
    int          run;
    int          m_coll;
    logic [CH-1:0] hist [0:SS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        m_sel  = 0;
        run    = 0;
        m_coll = 0;
        for (int k = 0; k <= SS; k++) hist[k] = '1;
    endtask

    // One clock edge of the model: the selector reacts to csn as sampled SS edges ago.
    task automatic model_edge();
        logic [CH-1:0] seen, prev;
        int falls;
        seen = hist[SS-1];
        prev = hist[SS];
        if (owner >= 0) begin
            falls = 0;
            for (int j = 0; j < CH; j++)
                if (j != owner && prev[j] && !seen[j]) falls++;
            m_coll = (m_coll + falls > 255) ? 255 : m_coll + falls;
            if (seen[owner]) run++;
            else run = 0;
            if (run == HO + 1) begin
                run = 0;
`ifndef MCU_SPI_SEL_STICKY_EN
                owner = -1;
`endif
            end
        end else begin
            for (int i = CH - 1; i >= 0; i--)
                if (!seen[i]) owner = i;
            if (owner >= 0) begin
                m_sel = owner;
                run   = 0;
            end
        end
        for (int k = SS; k >= 1; k--) hist[k] = hist[k-1];
        hist[0] = bus.mcu_csn_in;
    endtask

    task automatic check_outputs();
        logic [CH-1:0] em, ei;
        logic ecsn, esclk, emosi;
        em = '1;
        ei = {CH{bus.core_intn}};
        ecsn = 1'b1; esclk = 1'b0; emosi = 1'b1;
        if (owner >= 0) begin
            ei = '1;
            em[owner] = bus.core_miso;
            ei[owner] = bus.core_intn;
            ecsn  = bus.mcu_csn_in[owner];
            esclk = bus.mcu_sclk_in[owner];
            emosi = bus.mcu_mosi_in[owner];
        end
        chk("locked", 32'(locked), 32'(owner >= 0));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("collisions", 32'(collisions), 32'(m_coll));
        chk("core_csn", 32'(bus.core_csn), 32'(ecsn));
        chk("core_sclk", 32'(bus.core_sclk), 32'(esclk));
        chk("core_mosi", 32'(bus.core_mosi), 32'(emosi));
        chk("mcu_miso_out", 32'(bus.mcu_miso_out), 32'(em));
        chk("mcu_intn_out", 32'(bus.mcu_intn_out), 32'(ei));
    endtask

    task automatic rand_data();
        bus.mcu_sclk_in = CH'($urandom);
        bus.mcu_mosi_in = CH'($urandom);
        bus.core_miso   = 1'($urandom);
        bus.core_intn   = 1'($urandom);
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk32);
            model_edge();
            @(negedge clk32);
            check_outputs();
            rand_data();
        end
    endtask

    initial begin
        bus.mcu_csn_in = '1;
        rand_data();
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk32);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_core_csn", 32'(bus.core_csn), 32'd1);
        chk("rst_collisions", 32'(collisions), 32'd0);
        chk("rst_miso", 32'(bus.mcu_miso_out), 32'h3);
        reset = 1'b0;
        model_reset();

`ifdef MCU_SPI_SEL_STICKY_EN
        // Sticky: link 0 used, idle long past the holdoff, then link 1 tries.
        bus.mcu_csn_in[0] = 1'b0;
        step(10);
        bus.mcu_csn_in[0] = 1'b1;
        step(200);
        bus.mcu_csn_in[1] = 1'b0;
        step(6);
        chk("sticky_sel", 32'(sel), 32'd0);
        chk("sticky_core_csn", 32'(bus.core_csn), 32'd1);
        chk("sticky_coll", 32'(collisions), 32'd1);
        chk("sticky_locked", 32'(locked), 32'd1);
        bus.mcu_csn_in = '1;
        step(10);
`else
        // Single link: csn[1] falls, owned after SYNC_STAGES+1 edges.
        bus.mcu_csn_in[1] = 1'b0;
        step(2);
        chk("lock_early", 32'(locked), 32'd0);
        step(1);
        chk("lock_sel", 32'(sel), 32'd1);
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_core_csn", 32'(bus.core_csn), 32'd0);
        step(32);
        bus.mcu_csn_in[1] = 1'b1;
        step(HO + SS + 8);
        chk("single_released", 32'(locked), 32'd0);

        // Holdoff: a short high gap keeps the lock, a long one releases it.
        bus.mcu_csn_in[0] = 1'b0;
        step(6);
        bus.mcu_csn_in[0] = 1'b1;
        step(HO - 1);
        bus.mcu_csn_in[0] = 1'b0;
        step(6);
        chk("holdoff_short", 32'(locked), 32'd1);
        bus.mcu_csn_in[0] = 1'b1;
        step(HO + SS + 6);
        chk("holdoff_long_locked", 32'(locked), 32'd0);
        chk("holdoff_long_csn", 32'(bus.core_csn), 32'd1);

        // Tie: both links fall together; the lower one wins, no collision.
        bus.mcu_csn_in = 2'b00;
        step(5);
        chk("tie_sel", 32'(sel), 32'd0);
        chk("tie_coll", 32'(collisions), 32'd0);
        bus.mcu_csn_in[1] = 1'b1;
        step(4);
        bus.mcu_csn_in[1] = 1'b0;
        step(4);
        chk("tie_retry_coll", 32'(collisions), 32'd1);

        // Saturation: 300 pulses on the rejected link.
        for (int p = 0; p < 300; p++) begin
            bus.mcu_csn_in[1] = 1'b1;
            step(3);
            bus.mcu_csn_in[1] = 1'b0;
            step(3);
        end
        chk("sat_coll", 32'(collisions), 32'd255);
        bus.mcu_csn_in = '1;
        step(HO + SS + 8);
`endif

        // Randomised csn activity against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < CH; b++)
                if ($urandom_range(7) == 0) bus.mcu_csn_in[b] = ~bus.mcu_csn_in[b];
            step(1);
        end

        // Reset in the middle of a transfer forces core_csn high at once.
        bus.mcu_csn_in = '1;
        step(HO + SS + 8);
        bus.mcu_csn_in[1] = 1'b0;
        step(6);
        #2 reset = 1'b1;
        #1;
        chk("midrst_core_csn", 32'(bus.core_csn), 32'd1);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_coll", 32'(collisions), 32'd0);
        bus.mcu_csn_in = '1;
        @(negedge clk32);
        reset = 1'b0;
        model_reset();

        // After reset a fresh selection works again.
        bus.mcu_csn_in[0] = 1'b0;
        step(3);
        chk("post_rst_lock", 32'(locked), 32'd1);
        chk("post_rst_sel", 32'(sel), 32'd0);
        bus.mcu_csn_in = '1;
        step(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
